alu_result_checker: RTL and testbench

ALU_RESULT_CHECKER -- requirements
Module: alu_result_checker

---
 rtl/alu_result_checker_if.sv | 22 ++
 rtl/alu_result_checker.sv | 149 ++++++++++++++
 tb/tb_alu_result_checker.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_result_checker_if.sv
// Sample bus between a stimulus source and the ALU result checker.
// Carries in_valid/in_ready plus op, operands a/b and the observed result.
interface alu_result_checker_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] result;

    modport master (
        output in_valid, op, a, b, result,
        input  in_ready
    );

    modport slave (
        input  in_valid, op, a, b, result,
        output in_ready
    );
endinterface

// File: rtl/alu_result_checker.sv
// ALU result checker: recomputes each sample's expected result and counts
// pass/fail. Ports: clk, rst_n, start/stop session pulses, sample bus
// (slave), pass_cnt, fail_cnt, first_fail_idx, fail_seen, busy, done, all_pass.
module alu_result_checker #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   stop,
    alu_result_checker_if.slave    bus,
    output logic [CNT_W-1:0]       pass_cnt,
    output logic [CNT_W-1:0]       fail_cnt,
    output logic [CNT_W-1:0]       first_fail_idx,
    output logic                   fail_seen,
    output logic                   busy,
    output logic                   done,
    output logic                   all_pass
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state;
    state_t           state_nx;

    logic             s1_valid;
    logic [2:0]       s1_op;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [WIDTH-1:0] s1_res;
    logic [CNT_W-1:0] s1_idx;
    logic [CNT_W-1:0] idx;

    logic             ready;
    logic             accept;
    logic [WIDTH-1:0] expect_v;
    logic             match;

    // A start in RUN flushes the pipeline, so nothing is accepted that cycle.
    assign ready        = (state == RUN) && !stop && !start;
    assign bus.in_ready = ready;
    assign accept       = bus.in_valid && ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (start) state_nx = RUN;
            RUN: begin
                if (start)     state_nx = RUN;
                else if (stop) state_nx = DRAIN;
            end
            DRAIN: begin
                if (start)          state_nx = RUN;
                else if (!s1_valid) state_nx = DONE;
            end
            DONE:  if (start) state_nx = RUN;
            default: state_nx = IDLE;
        endcase
    end

    // Stage 1: capture the accepted sample with its session index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_op    <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_res   <= '0;
            s1_idx   <= '0;
            idx      <= '0;
        end else if (start) begin
            s1_valid <= 1'b0;
            idx      <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_op  <= bus.op;
                s1_a   <= bus.a;
                s1_b   <= bus.b;
                s1_res <= bus.result;
                s1_idx <= idx;
                idx    <= idx + 1'b1;
            end
        end
    end

    always_comb begin
        expect_v = '0;
        unique case (s1_op)
            3'b000: expect_v = s1_a & s1_b;
            3'b001: expect_v = s1_a | s1_b;
            3'b010: expect_v = s1_a ^ s1_b;
            3'b011: expect_v = s1_a + s1_b;
            3'b100: expect_v = s1_a - s1_b;
            3'b101: expect_v = ~s1_a;
            3'b110: expect_v = {s1_a[WIDTH-2:0], 1'b0};
            3'b111: expect_v = {1'b0, s1_a[WIDTH-1:1]};
            default: expect_v = '0;
        endcase
    end

    assign match = (expect_v == s1_res);

    // Stage 2: score the stage-1 sample; counters saturate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_cnt       <= '0;
            fail_cnt       <= '0;
            first_fail_idx <= '0;
            fail_seen      <= 1'b0;
        end else if (start) begin
            pass_cnt       <= '0;
            fail_cnt       <= '0;
            first_fail_idx <= '0;
            fail_seen      <= 1'b0;
        end else if (s1_valid) begin
            if (match) begin
                if (pass_cnt != CNT_MAX) pass_cnt <= pass_cnt + 1'b1;
            end else begin
                if (fail_cnt != CNT_MAX) fail_cnt <= fail_cnt + 1'b1;
                if (!fail_seen) begin
                    first_fail_idx <= s1_idx;
                    fail_seen      <= 1'b1;
                end
            end
        end
    end

    assign busy     = (state == RUN) || (state == DRAIN);
    assign done     = (state == DONE);
    assign all_pass = done && (fail_cnt == '0) && (pass_cnt != '0);

endmodule

// File: tb/tb_alu_result_checker.sv
// Directed, table-driven bench for alu_result_checker.
// A second CNT_W=2 instance sees the same stimulus to exercise saturation.
module tb_alu_result_checker;

    localparam int WIDTH = 8;
    localparam int CNT_W = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic stop  = 1'b0;

    always #5 clk = ~clk;

    alu_result_checker_if #(.WIDTH(WIDTH)) bus ();
    alu_result_checker_if #(.WIDTH(WIDTH)) bus2 ();

    assign bus2.in_valid = bus.in_valid;
    assign bus2.op       = bus.op;
    assign bus2.a        = bus.a;
    assign bus2.b        = bus.b;
    assign bus2.result   = bus.result;

    logic [CNT_W-1:0] pass_cnt, fail_cnt, first_fail_idx;
    logic             fail_seen, busy, done, all_pass;
    logic [1:0]       pass2, fail2, ffi2;
    logic             fs2, busy2, done2, ap2;

    alu_result_checker #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .stop           (stop),
        .bus            (bus),
        .pass_cnt       (pass_cnt),
        .fail_cnt       (fail_cnt),
        .first_fail_idx (first_fail_idx),
        .fail_seen      (fail_seen),
        .busy           (busy),
        .done           (done),
        .all_pass       (all_pass)
    );

    alu_result_checker #(.WIDTH(WIDTH), .CNT_W(2)) dut2 (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .stop           (stop),
        .bus            (bus2),
        .pass_cnt       (pass2),
        .fail_cnt       (fail2),
        .first_fail_idx (ffi2),
        .fail_seen      (fs2),
        .busy           (busy2),
        .done           (done2),
        .all_pass       (ap2)
    );

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
    } vec_t;

    vec_t vt[22];
    int   total = 0;
    int   bad   = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_session(input int first, input int n,
                               input int ep, input int ef,
                               input int effi, input bit efs);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_busy", busy, 1);
        check("start_pass_clr", pass_cnt, 0);
        check("start_fail_clr", fail_cnt, 0);
        check("start_fs_clr", fail_seen, 0);
        for (int i = first; i < first + n; i++) begin
            bus.in_valid = 1'b1;
            bus.op       = vt[i].op;
            bus.a        = vt[i].a;
            bus.b        = vt[i].b;
            bus.result   = vt[i].res;
            #1;
            check("run_ready", bus.in_ready, 1);
            tick();
        end
        bus.in_valid = 1'b0;
        stop = 1'b1;
        #1;
        check("stop_ready", bus.in_ready, 0);
        tick();
        stop = 1'b0;
        check("drain_done", done, 0);
        check("drain_busy", busy, 1);
        tick();
        check("done", done, 1);
        check("done_busy", busy, 0);
        check("pass_cnt", pass_cnt, ep);
        check("fail_cnt", fail_cnt, ef);
        check("fail_seen", fail_seen, efs);
        if (efs) check("first_fail_idx", first_fail_idx, effi);
        check("all_pass", all_pass, (ef == 0 && ep != 0) ? 1 : 0);
    endtask

    initial begin
        // op 001 session
        vt[0]  = '{3'b001, 8'h00, 8'h00, 8'h00};
        vt[1]  = '{3'b001, 8'h00, 8'hD3, 8'hD3};
        vt[2]  = '{3'b001, 8'hFF, 8'h00, 8'hFF};
        vt[3]  = '{3'b001, 8'hFF, 8'hFF, 8'hFF};
        vt[4]  = '{3'b001, 8'hAA, 8'hCC, 8'hEE};
        vt[5]  = '{3'b001, 8'hEC, 8'h13, 8'hFF};
        // wrap-around arithmetic and shift
        vt[6]  = '{3'b011, 8'hFF, 8'h01, 8'h00};
        vt[7]  = '{3'b100, 8'h00, 8'h01, 8'hFF};
        vt[8]  = '{3'b110, 8'h81, 8'h00, 8'h02};
        // pass, fail, fail
        vt[9]  = '{3'b000, 8'hF0, 8'h3C, 8'h30};
        vt[10] = '{3'b010, 8'h0F, 8'h0F, 8'h01};
        vt[11] = '{3'b101, 8'h55, 8'h00, 8'h00};
        // mixed ops, fails at idx 5 and 6
        vt[12] = '{3'b111, 8'h81, 8'hFF, 8'h40};
        vt[13] = '{3'b101, 8'h0F, 8'h12, 8'hF0};
        vt[14] = '{3'b010, 8'hA5, 8'h5A, 8'hFF};
        vt[15] = '{3'b100, 8'h10, 8'h01, 8'h0F};
        vt[16] = '{3'b011, 8'h80, 8'h80, 8'h00};
        vt[17] = '{3'b111, 8'hFF, 8'h00, 8'hFF};
        vt[18] = '{3'b000, 8'hFF, 8'h0F, 8'h0E};
        // two passes for the reset-in-flight test
        vt[19] = '{3'b001, 8'h01, 8'h02, 8'h03};
        vt[20] = '{3'b000, 8'h0F, 8'h0F, 8'h0F};
        vt[21] = '{3'b110, 8'h01, 8'h00, 8'h02};

        bus.in_valid = 1'b0;
        bus.op       = '0;
        bus.a        = '0;
        bus.b        = '0;
        bus.result   = '0;

        #3;
        check("rst_ready", bus.in_ready, 0);
        check("rst_pass", pass_cnt, 0);
        check("rst_fail", fail_cnt, 0);
        check("rst_ffi", first_fail_idx, 0);
        check("rst_fs", fail_seen, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_all_pass", all_pass, 0);
        tick();
        rst_n = 1'b1;
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("idle_stop_busy", busy, 0);

        run_session(0, 6, 6, 0, 0, 1'b0);
        check("sat_pass2", pass2, 3);
        check("sat_fail2", fail2, 0);

        // DONE holds while garbage is offered
        bus.in_valid = 1'b1;
        bus.op       = 3'b000;
        bus.a        = 8'h12;
        bus.result   = 8'h99;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("done_ready", bus.in_ready, 0);
            tick();
        end
        bus.in_valid = 1'b0;
        check("hold_pass", pass_cnt, 6);
        check("hold_fail", fail_cnt, 0);
        check("hold_done", done, 1);
        check("hold_all_pass", all_pass, 1);

        run_session(6, 3, 3, 0, 0, 1'b0);
        run_session(9, 3, 1, 2, 1, 1'b1);
        run_session(12, 7, 5, 2, 5, 1'b1);
        check("sat_pass2_mix", pass2, 3);
        check("cnt_fail2_mix", fail2, 2);

        // async reset with samples in flight
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 19; i < 21; i++) begin
            bus.in_valid = 1'b1;
            bus.op       = vt[i].op;
            bus.a        = vt[i].a;
            bus.b        = vt[i].b;
            bus.result   = vt[i].res;
            tick();
        end
        bus.in_valid = 1'b0;
        check("pre_rst_pass", pass_cnt, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_ready", bus.in_ready, 0);
        check("arst_pass", pass_cnt, 0);
        check("arst_fail", fail_cnt, 0);
        check("arst_ffi", first_fail_idx, 0);
        check("arst_fs", fail_seen, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_all_pass", all_pass, 0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        check("post_rst_pass", pass_cnt, 0);
        check("post_rst_busy", busy, 0);

        // start wins over stop
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        check("ss_busy", busy, 1);
        check("ss_done", done, 0);
        #1;
        check("ss_ready", bus.in_ready, 1);

        // one sample then stop: counted, done two edges after stop
        bus.in_valid = 1'b1;
        bus.op       = vt[21].op;
        bus.a        = vt[21].a;
        bus.b        = vt[21].b;
        bus.result   = vt[21].res;
        tick();
        bus.in_valid = 1'b0;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("late_done0", done, 0);
        tick();
        check("late_done1", done, 1);
        check("late_pass", pass_cnt, 1);
        check("late_all_pass", all_pass, 1);

        // empty session ends with all_pass low
        start = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b1;
        tick();
        stop = 1'b0;
        tick();
        check("empty_done", done, 1);
        check("empty_all_pass", all_pass, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
